fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined RISC-V core; replaces the single-cycle PC register + PC+4/branch mux.
- Owns the PC, reads instruction memory each cycle, buffers {pc, inst} pairs in a DEPTH-entry FIFO, and hands them to decode with a valid/ready handshake.
- Supports branch/jump redirect with queue flush, a halt input, and a debug readout bus for LEDs/SSD.

Parameters:
- XLEN, 32, width of PC and instruction.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- IMEM_ADDR_W, 6, word-index bits driven to instruction memory.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  IMEM_ADDR_W  word address, always equal to pc[IMEM_ADDR_W+1:2].
- imem_data  in  XLEN  instruction at imem_addr; combinational read, valid in the same cycle.
- out_valid  out  1  FIFO head holds a valid entry.
- out_inst  out  XLEN  head instruction; 32'h0000_0013 (NOP) when out_valid=0.
- out_pc  out  XLEN  head PC; 0 when out_valid=0.
- out_ready  in  1  decode accepts the head this cycle.
- redirect_valid  in  1  taken branch/jump/flush request.
- redirect_pc  in  XLEN  target PC; bits [1:0] ignored.
- halt  in  1  suppresses new fetches; the queue still drains.
- fetch_pc  out  XLEN  current fetch PC.
- dbg_sel  in  2  debug select.
- dbg_out  out  16  0: fetch_pc[15:0], 1: out_inst[15:0], 2: out_inst[31:16], 3: {count padded to 8 bits, redirect_cnt[7:0]}.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; count, rd_ptr, wr_ptr = 0; redirect_cnt=0; out_valid=0; out_inst=NOP; out_pc=0. Outputs take these values immediately, without a clock edge.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & ~halt & ((count < DEPTH) | pop).
  - A full queue with a simultaneous pop still pushes.
- On push:
  - Write {pc, imem_data} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - pc <= pc + 4, modulo 2^XLEN.
- On pop: rd_ptr advances modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Never push when count==DEPTH without a pop; never pop when count==0 (out_valid=0).
- Redirect has priority over everything in the same cycle:
  - count, rd_ptr, wr_ptr <= 0.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No push and no pop.
  - A handshake asserted by decode in that cycle is discarded.
  - redirect_cnt increments and saturates at 8'hFF.
- Redirect latency:
  - Redirect sampled at edge N → imem_addr shows the target during cycle N+1 → push at edge N+1 → out_valid=1 with out_pc=target from edge N+1 on.
  - This assumes halt=0.
- Start-up: the first edge after reset release pushes RESET_PC; out_valid rises after that edge.
- Halt:
  - The PC holds.
  - Queued entries keep draining via out_ready.
  - A redirect during halt still updates pc and flushes.
- Back-to-back redirects: the last one wins; each increments redirect_cnt.
- Throughput: with out_ready held high and no redirect/halt, one instruction per cycle is sustained indefinitely.
- imem_addr, out_*, fetch_pc, dbg_out are combinational from state. No other output depends combinationally on out_ready.

Test Plan:
- Reset then free run, out_ready=1, imem_data=pc-tagged pattern → out_pc sequence 0x0, 0x4, 0x8, … one per cycle; first out_valid one edge after reset release.
- Hold out_ready=0, DEPTH=4 → count reaches 4 after 4 edges and fetch_pc freezes at 0x10. Then out_ready=1 → pops 0x0, 0x4, 0x8, 0xC in order with no bubble, and 0x10 follows immediately.
- Queue full with out_ready=1 and redirect_valid=1, redirect_pc=0x43 → next cycle out_valid=0 and fetch_pc=0x40; one edge later out_pc=0x40; dbg_sel=3 shows redirect_cnt=1.
- halt=1 with 3 entries queued and out_ready=1 → 3 pops, then out_valid=0, out_inst=0x00000013; fetch_pc unchanged. Releasing halt resumes at the held PC.
- rst asserted mid-stream with count=2 → out_valid=0 and fetch_pc=RESET_PC without a clock edge; after release, the sequence restarts at RESET_PC.
- RESET_PC=0xFFFF_FFF8, free run → out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); imem_addr follows pc[7:2].

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Fetch-to-decode bus for fetch_queue_unit.
// It also carries the instruction-memory port, the redirect/halt controls and the debug readout.
interface fetch_queue_unit_if #(
  parameter int XLEN        = 32,
  parameter int IMEM_ADDR_W = 6
);
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]        imem_data;
  logic                   out_valid;
  logic [XLEN-1:0]        out_inst;
  logic [XLEN-1:0]        out_pc;
  logic                   out_ready;
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   halt;
  logic [XLEN-1:0]        fetch_pc;
  logic [1:0]             dbg_sel;
  logic [15:0]            dbg_out;

  modport master (
    output imem_addr, out_valid, out_inst, out_pc, fetch_pc, dbg_out,
    input  imem_data, out_ready, redirect_valid, redirect_pc, halt, dbg_sel
  );

  modport slave (
    input  imem_addr, out_valid, out_inst, out_pc, fetch_pc, dbg_out,
    output imem_data, out_ready, redirect_valid, redirect_pc, halt, dbg_sel
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end that owns the PC and reads instruction memory each cycle.
// It queues {pc, inst} pairs for decode and flushes the queue on a redirect.
module fetch_queue_unit #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter int              IMEM_ADDR_W = 6,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic               clk,
  input logic               rst,
  fetch_queue_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  NOP_INST  = XLEN'(32'h0000_0013);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       redirect_cnt_q, redirect_cnt_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic out_valid;
  logic push;
  logic pop;
  logic [15:0] dbg_out_w;

  assign out_valid = (count_q != '0);

  // A redirect squashes both the handshake and the fetch in its cycle.
  assign pop  = out_valid & bus.out_ready & ~bus.redirect_valid;
  assign push = ~bus.redirect_valid & ~bus.halt & ((count_q < DEPTH_CNT) | pop);

  always_comb begin
    pc_d           = pc_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    redirect_cnt_d = redirect_cnt_q;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc & ~XLEN'(3);
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (redirect_cnt_q != 8'hFF) begin
        redirect_cnt_d = redirect_cnt_q + 8'd1;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      redirect_cnt_q <= '0;
    end else begin
      pc_q           <= pc_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Payload storage needs no reset; count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= bus.imem_data;
    end
  end

  always_comb begin
    dbg_out_w = '0;
    case (bus.dbg_sel)
      2'd0:    dbg_out_w = pc_q[15:0];
      2'd1:    dbg_out_w = bus.out_inst[15:0];
      2'd2:    dbg_out_w = bus.out_inst[31:16];
      default: dbg_out_w = {8'(count_q), redirect_cnt_q};
    endcase
  end

  assign bus.imem_addr = pc_q[IMEM_ADDR_W+1:2];
  assign bus.fetch_pc  = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = out_valid ? inst_mem[rd_ptr_q] : NOP_INST;
  assign bus.out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.dbg_out   = dbg_out_w;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: stimulus queues expected {pc, inst} pairs,
// and per-DUT monitors compare them on every accepted handshake.
module tb_fetch_queue_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk;
  logic rst;
  logic rst2;
  int   total;
  int   bad;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  fetch_queue_unit_if #(.XLEN(32), .IMEM_ADDR_W(6)) ifc ();
  fetch_queue_unit_if #(.XLEN(32), .IMEM_ADDR_W(6)) ifc2 ();

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .IMEM_ADDR_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(ifc.master)
  );

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .IMEM_ADDR_W(6), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .bus(ifc2.master)
  );

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    return {8'hC0, 18'h0, a};
  endfunction

  assign ifc.imem_data  = mem_word(ifc.imem_addr);
  assign ifc2.imem_data = mem_word(ifc2.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.inst = mem_word(p[7:2]);
    exp_q.push_back(e);
  endtask

  task automatic push_exp2(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.inst = mem_word(p[7:2]);
    exp2_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_drain2(input string name, input int budget);
    for (int i = 0; i < budget && exp2_q.size() != 0; i++) tick();
    chk(name, exp2_q.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_pulse_valid", 32'(ifc.out_valid), 0);
    chk("rst_pulse_fetch_pc", ifc.fetch_pc, 32'h0);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ifc.out_valid && ifc.out_ready && !ifc.redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual_pc=%h required=none", ifc.out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("pop pc=%h inst=%h exp_pc=%h", ifc.out_pc, ifc.out_inst, e.pc);
        chk("sb_pc", ifc.out_pc, e.pc);
        chk("sb_inst", ifc.out_inst, e.inst);
      end
    end
  end

  always @(negedge clk) begin
    if (ifc2.out_valid && ifc2.out_ready && !ifc2.redirect_valid) begin
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb2_unexpected actual_pc=%h required=none", ifc2.out_pc);
      end else begin
        exp_t e;
        e = exp2_q.pop_front();
        $display("pop2 pc=%h inst=%h exp_pc=%h", ifc2.out_pc, ifc2.out_inst, e.pc);
        chk("sb2_pc", ifc2.out_pc, e.pc);
        chk("sb2_inst", ifc2.out_inst, e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rst2  = 1'b1;
    ifc.out_ready       = 1'b1;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = '0;
    ifc.halt            = 1'b0;
    ifc.dbg_sel         = 2'd3;
    ifc2.out_ready      = 1'b1;
    ifc2.redirect_valid = 1'b0;
    ifc2.redirect_pc    = '0;
    ifc2.halt           = 1'b0;
    ifc2.dbg_sel        = 2'd0;

    // reset state
    #2;
    chk("rst_valid", 32'(ifc.out_valid), 0);
    chk("rst_inst", ifc.out_inst, 32'h0000_0013);
    chk("rst_pc", ifc.out_pc, 32'h0);
    chk("rst_fetch_pc", ifc.fetch_pc, 32'h0);
    chk("rst_imem_addr", 32'(ifc.imem_addr), 0);
    chk("rst_dbg", 32'(ifc.dbg_out), 0);

    // free run: one instruction per cycle from RESET_PC
    tick();
    tick();
    rst = 1'b0;
    chk("t1_pre_valid", 32'(ifc.out_valid), 0);
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    tick();
    chk("t1_first_valid", 32'(ifc.out_valid), 1);
    chk("t1_first_pc", ifc.out_pc, 32'h0);
    wait_drain("t1_drain", 20);
    ifc.out_ready = 1'b0;
    tick();

    // fill with out_ready low, then drain with no bubble
    pulse_reset();
    repeat (4) tick();
    chk("t2_full_fetch_pc", ifc.fetch_pc, 32'h10);
    chk("t2_full_dbg", 32'(ifc.dbg_out), 32'h0400);
    tick();
    chk("t2_frozen_fetch_pc", ifc.fetch_pc, 32'h10);
    for (int i = 0; i < 5; i++) push_exp(32'(i * 4));
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_no_bubble", 32'(ifc.out_valid), 1);
    end
    chk("t2_sb_empty", exp_q.size(), 0);

    // redirect while full with a handshake pending
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h43;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("t3_flush_valid", 32'(ifc.out_valid), 0);
    chk("t3_fetch_pc", ifc.fetch_pc, 32'h40);
    chk("t3_imem_addr", 32'(ifc.imem_addr), 32'h10);
    chk("t3_dbg_cnt", 32'(ifc.dbg_out), 32'h0001);
    push_exp(32'h40);
    tick();
    chk("t3_target_valid", 32'(ifc.out_valid), 1);
    chk("t3_target_pc", ifc.out_pc, 32'h40);
    wait_drain("t3_drain", 10);
    ifc.out_ready = 1'b0;
    tick();

    // halt with three entries queued
    pulse_reset();
    repeat (3) tick();
    chk("t4_count3", 32'(ifc.dbg_out), 32'h0300);
    ifc.halt      = 1'b1;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(32'(i * 4));
    wait_drain("t4_drain", 10);
    chk("t4_empty_valid", 32'(ifc.out_valid), 0);
    chk("t4_empty_inst", ifc.out_inst, 32'h0000_0013);
    chk("t4_empty_pc", ifc.out_pc, 32'h0);
    chk("t4_held_pc", ifc.fetch_pc, 32'hC);
    tick();
    chk("t4_still_held", ifc.fetch_pc, 32'hC);
    ifc.halt = 1'b0;
    push_exp(32'hC);
    push_exp(32'h10);
    wait_drain("t4_resume", 10);
    ifc.out_ready = 1'b0;
    tick();

    // asynchronous reset mid-stream
    pulse_reset();
    repeat (2) tick();
    chk("t5_count2", 32'(ifc.dbg_out), 32'h0200);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(ifc.out_valid), 0);
    chk("t5_async_inst", ifc.out_inst, 32'h0000_0013);
    chk("t5_async_fetch_pc", ifc.fetch_pc, 32'h0);
    chk("t5_async_dbg", 32'(ifc.dbg_out), 32'h0000);
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(32'(i * 4));
    wait_drain("t5_restart", 10);
    ifc.out_ready = 1'b0;
    tick();

    // PC wrap on the second instance
    rst2 = 1'b0;
    chk("t6_fetch_pc", ifc2.fetch_pc, 32'hFFFF_FFF8);
    chk("t6_imem_addr0", 32'(ifc2.imem_addr), 32'h3E);
    push_exp2(32'hFFFF_FFF8);
    push_exp2(32'hFFFF_FFFC);
    push_exp2(32'h0000_0000);
    tick();
    chk("t6_imem_addr1", 32'(ifc2.imem_addr), 32'h3F);
    tick();
    chk("t6_imem_addr2", 32'(ifc2.imem_addr), 32'h00);
    chk("t6_wrap_pc", ifc2.fetch_pc, 32'h0);
    wait_drain2("t6_drain", 10);
    ifc2.out_ready = 1'b0;
    tick();

    // back-to-back redirects: the last target wins, each one counts
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h100;
    tick();
    ifc.redirect_pc    = 32'h205;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("t7_fetch_pc", ifc.fetch_pc, 32'h204);
    chk("t7_dbg_cnt", 32'(ifc.dbg_out), 32'h0002);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
